alu_mc: RTL and testbench

Multi-cycle, width-parametrised successor to the CR16 single-cycle ALU; sits between the register file read ports and the writeback mux in the CR16 datapath. Keeps the 4-bit opcode map and 5-bit status encoding, adds a start/busy/done handshake, a persistent carry register feeding ADDC/ADDCU, an iterative shift-add multiplier and an optional iterative unsigned divider. All outputs are registered.

---
 rtl/cr16_pkg.sv | 46 ++++
 rtl/alu_mc_iter.sv | 81 ++++++++
 rtl/alu_mc.sv | 167 ++++++++++++++++
 tb/tb_alu_mc.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared CR16 ALU definitions: opcode map, status bit positions, sequencer states.
package cr16_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_ADDC  = 4'd2;
  localparam logic [3:0] OP_ADDCU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NOT   = 4'd10;
  localparam logic [3:0] OP_LSH   = 4'd11;
  localparam logic [3:0] OP_RSH   = 4'd12;
  localparam logic [3:0] OP_ALSH  = 4'd13;
  localparam logic [3:0] OP_ARSH  = 4'd14;
  localparam logic [3:0] OP_DIVU  = 4'd15;

  localparam int STATUS_INDEX_CARRY    = 0;
  localparam int STATUS_INDEX_LOW      = 1;
  localparam int STATUS_INDEX_FLAG     = 2;
  localparam int STATUS_INDEX_ZERO     = 3;
  localparam int STATUS_INDEX_NEGATIVE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic [4:0] mk_status(input logic neg, input logic zero,
                                           input logic flag, input logic low,
                                           input logic carry);
    logic [4:0] st;
    st = '0;
    st[STATUS_INDEX_NEGATIVE] = neg;
    st[STATUS_INDEX_ZERO]     = zero;
    st[STATUS_INDEX_FLAG]     = flag;
    st[STATUS_INDEX_LOW]      = low;
    st[STATUS_INDEX_CARRY]    = carry;
    return st;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// W-cycle iterative datapath shared by shift-add multiply and restoring divide.
// The divide path exists only when ALU_MC_DIV_EN is defined.
module alu_mc_iter
  import cr16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         run_i,
  input  logic         div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o,
  output logic         last_o
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] cnt_q;
  logic          div_q;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  opd_q, opd_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  mul_acc;
`ifdef ALU_MC_DIV_EN
  logic [W:0]    trial;
`endif

  // acc: partial product / remainder; opd: multiplicand / divisor;
  // sh: multiplier (shifted out LSB first) / dividend becoming quotient.
  always_comb begin
    mul_acc = acc_q + (sh_q[0] ? opd_q : '0);
    acc_d   = mul_acc;
    opd_d   = opd_q << 1;
    sh_d    = sh_q >> 1;
`ifdef ALU_MC_DIV_EN
    trial   = {acc_q, sh_q[W-1]} - {1'b0, opd_q};
    if (div_q) begin
      opd_d = opd_q;
      if (!trial[W]) begin
        acc_d = trial[W-1:0];
        sh_d  = {sh_q[W-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[W-2:0], sh_q[W-1]};
        sh_d  = {sh_q[W-2:0], 1'b0};
      end
    end
    res_o = div_q ? sh_d : acc_d;
`else
    res_o = div_q ? '0 : acc_d;
`endif
  end

  assign last_o = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      acc_q <= '0;
      opd_q <= b_i;
      sh_q  <= a_i;
      div_q <= div_i;
    end else if (run_i) begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle CR16 ALU: start/busy/done handshake, persistent carry, iterative MUL.
// Define ALU_MC_DIV_EN to enable the iterative unsigned divider on opcode 15.
module alu_mc
  import cr16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_START,
  input  logic [3:0]            I_OPCODE,
  input  logic [DATA_WIDTH-1:0] I_A,
  input  logic [DATA_WIDTH-1:0] I_B,
  output logic [DATA_WIDTH-1:0] O_C,
  output logic [4:0]            O_STATUS,
  output logic                  O_BUSY,
  output logic                  O_DONE
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] SH_LIM = W'(W);

  state_e       state_q;
  logic [W-1:0] c_q;
  logic [4:0]   status_q;
  logic         busy_q, done_q, carry_q;

  logic         accept;
  logic         cin, big_sh;
  logic [W:0]   add_ext;
  logic [W-1:0] arsh_v;
  logic [W-1:0] sc_c;
  logic [4:0]   sc_st;
  logic         flag, neg, low, cy, zero_en;
  logic         carry_we, carry_nx, mc_op, mc_div;
  logic [W-1:0] it_res;
  logic         it_last;
  logic [4:0]   it_st;

  assign accept  = I_START & ~busy_q;
  assign cin     = carry_q & ((I_OPCODE == OP_ADDC) | (I_OPCODE == OP_ADDCU));
  assign add_ext = {1'b0, I_A} + {1'b0, I_B} + (W + 1)'(cin);
  assign big_sh  = (I_B >= SH_LIM);
  assign arsh_v  = $signed(I_A) >>> I_B;

  always_comb begin
    sc_c     = '0;
    flag     = 1'b0;
    neg      = 1'b0;
    low      = 1'b0;
    cy       = 1'b0;
    zero_en  = 1'b1;
    carry_we = 1'b0;
    carry_nx = carry_q;
    mc_op    = 1'b0;
    mc_div   = 1'b0;
    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        sc_c     = add_ext[W-1:0];
        flag     = (I_A[W-1] == I_B[W-1]) && (sc_c[W-1] != I_A[W-1]);
        neg      = sc_c[W-1];
        carry_we = 1'b1;
        carry_nx = add_ext[W];
      end
      OP_ADDU, OP_ADDCU: begin
        sc_c     = add_ext[W-1:0];
        cy       = add_ext[W];
        carry_we = 1'b1;
        carry_nx = add_ext[W];
      end
      // Subtract order is B minus A; N reports the true signed compare.
      OP_SUB: begin
        sc_c     = I_B - I_A;
        flag     = (I_A[W-1] != I_B[W-1]) && (sc_c[W-1] != I_B[W-1]);
        neg      = $signed(I_B) < $signed(I_A);
        carry_we = 1'b1;
        carry_nx = I_B < I_A;
      end
      OP_SUBU: begin
        sc_c     = I_B - I_A;
        low      = I_B < I_A;
        cy       = low;
        carry_we = 1'b1;
        carry_nx = low;
      end
      OP_MUL:  mc_op = 1'b1;
      OP_AND:  sc_c = I_A & I_B;
      OP_OR:   sc_c = I_A | I_B;
      OP_XOR:  sc_c = I_A ^ I_B;
      OP_NOT:  sc_c = ~I_A;
      OP_LSH, OP_ALSH: sc_c = big_sh ? '0 : (I_A << I_B);
      OP_RSH:  sc_c = big_sh ? '0 : (I_A >> I_B);
      OP_ARSH: sc_c = big_sh ? {W{I_A[W-1]}} : arsh_v;
      default: begin
        zero_en = 1'b0;
`ifdef ALU_MC_DIV_EN
        if (I_B == '0) begin
          sc_c = '1;
          flag = 1'b1;
        end else begin
          mc_op  = 1'b1;
          mc_div = 1'b1;
        end
`endif
      end
    endcase
    sc_st = mk_status(neg, zero_en & (sc_c == '0), flag, low, cy);
  end

  alu_mc_iter #(.W(W)) u_iter (
    .clk_i  (I_CLK),
    .rst_ni (I_NRESET),
    .load_i (accept & mc_op),
    .run_i  (busy_q),
    .div_i  (mc_div),
    .a_i    (I_A),
    .b_i    (I_B),
    .res_o  (it_res),
    .last_o (it_last)
  );

  assign it_st = mk_status((state_q == ST_MUL) & it_res[W-1], it_res == '0,
                           1'b0, 1'b0, 1'b0);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (mc_op) begin
              state_q <= mc_div ? ST_DIV : ST_MUL;
              busy_q  <= 1'b1;
            end else begin
              c_q      <= sc_c;
              status_q <= sc_st;
              done_q   <= 1'b1;
              if (carry_we) carry_q <= carry_nx;
            end
          end
        end
        default: begin
          if (it_last) begin
            c_q      <= it_res;
            status_q <= it_st;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign O_C      = c_q;
  assign O_STATUS = status_q;
  assign O_BUSY   = busy_q;
  assign O_DONE   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=16): directed table, handshake corner
// sequences and randomized ops against a behavioural model. Honours ALU_MC_DIV_EN.
module tb_alu_mc;
  import cr16_pkg::*;

  localparam int W = 16;

  logic          I_CLK = 1'b0;
  logic          I_NRESET;
  logic          I_START;
  logic [3:0]    I_OPCODE;
  logic [W-1:0]  I_A, I_B;
  logic [W-1:0]  O_C;
  logic [4:0]    O_STATUS;
  logic          O_BUSY, O_DONE;

  int vectors = 0;
  int miscompares = 0;
  bit m_carry = 1'b0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .I_CLK    (I_CLK),
    .I_NRESET (I_NRESET),
    .I_START  (I_START),
    .I_OPCODE (I_OPCODE),
    .I_A      (I_A),
    .I_B      (I_B),
    .O_C      (O_C),
    .O_STATUS (O_STATUS),
    .O_BUSY   (O_BUSY),
    .O_DONE   (O_DONE)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [4:0]  st;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic; lat counts sampling
  // negedges from the accept edge until O_DONE is seen (1 = next cycle).
  function automatic void model(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] c,
                                output logic [4:0] st, output int lat);
    longint sa, sb, ua, ub, r, cin;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    cin = ((op == OP_ADDC) || (op == OP_ADDCU)) ? longint'(m_carry) : 0;
    c = '0;
    st = '0;
    lat = 1;
    case (op)
      OP_ADD, OP_ADDC: begin
        r = sa + sb + cin;
        c = r[15:0];
        st[2] = (r > 32767) || (r < -32768);
        st[4] = c[15];
        st[3] = (c == 16'h0);
        r = ua + ub + cin;
        m_carry = (r > 65535);
      end
      OP_ADDU, OP_ADDCU: begin
        r = ua + ub + cin;
        c = r[15:0];
        st[0] = (r > 65535);
        st[3] = (c == 16'h0);
        m_carry = st[0];
      end
      OP_SUB: begin
        r = sb - sa;
        c = r[15:0];
        st[2] = (r > 32767) || (r < -32768);
        st[4] = (sb < sa);
        st[3] = (c == 16'h0);
        m_carry = (ub < ua);
      end
      OP_SUBU: begin
        r = ub - ua;
        c = r[15:0];
        st[0] = (ub < ua);
        st[1] = (ub < ua);
        st[3] = (c == 16'h0);
        m_carry = (ub < ua);
      end
      OP_MUL: begin
        r = ua * ub;
        c = r[15:0];
        st[4] = c[15];
        st[3] = (c == 16'h0);
        lat = W + 1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_LSH, OP_ALSH, OP_RSH, OP_ARSH: begin
        case (op)
          OP_AND:  c = a & b;
          OP_OR:   c = a | b;
          OP_XOR:  c = a ^ b;
          OP_NOT:  c = ~a;
          OP_RSH:  begin r = (ub >= 16) ? 0 : (ua >> ub); c = r[15:0]; end
          OP_ARSH: begin
            if (ub >= 16) c = a[15] ? 16'hFFFF : 16'h0000;
            else begin r = sa >>> ub; c = r[15:0]; end
          end
          default: begin r = (ub >= 16) ? 0 : (ua << ub); c = r[15:0]; end
        endcase
        st[3] = (c == 16'h0);
      end
      default: begin
`ifdef ALU_MC_DIV_EN
        if (ub == 0) begin
          c = 16'hFFFF;
          st = 5'b00100;
        end else begin
          r = ua / ub;
          c = r[15:0];
          st[3] = (c == 16'h0);
          lat = W + 1;
        end
`endif
      end
    endcase
  endfunction

  // One transaction; operands are scrambled right after accept.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] c, output logic [4:0] st, output int lat);
    @(negedge I_CLK);
    I_START = 1'b1;
    I_OPCODE = op;
    I_A = a;
    I_B = b;
    @(posedge I_CLK);
    @(negedge I_CLK);
    I_START = 1'b0;
    I_OPCODE = 4'($urandom);
    I_A = 16'($urandom);
    I_B = 16'($urandom);
    lat = 1;
    while (!O_DONE && lat < 100) begin
      @(negedge I_CLK);
      lat++;
    end
    c = O_C;
    st = O_STATUS;
  endtask

  logic [15:0] rc, ec;
  logic [4:0]  rs, es;
  int          rl, el;

  initial begin
    I_NRESET = 1'b0;
    I_START = 1'b0;
    I_OPCODE = '0;
    I_A = '0;
    I_B = '0;

    tbl.push_back('{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 5'b10100, 1});
    tbl.push_back('{OP_ADDU,  16'hFFFF, 16'h0001, 16'h0000, 5'b01001, 1});
    tbl.push_back('{OP_ADDCU, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1});
    tbl.push_back('{OP_ADDCU, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 1});
    tbl.push_back('{OP_SUBU,  16'h0005, 16'h0003, 16'hFFFE, 5'b00011, 1});
    tbl.push_back('{OP_ADDC,  16'h7FFF, 16'h0000, 16'h8000, 5'b10100, 1});
    tbl.push_back('{OP_SUB,   16'h0003, 16'hFFFE, 16'hFFFB, 5'b10000, 1});
    tbl.push_back('{OP_SUB,   16'h8000, 16'h0001, 16'h8001, 5'b00100, 1});
    tbl.push_back('{OP_LSH,   16'h0001, 16'd16,   16'h0000, 5'b01000, 1});
    tbl.push_back('{OP_ARSH,  16'h8000, 16'd20,   16'hFFFF, 5'b00000, 1});
    tbl.push_back('{OP_RSH,   16'h8000, 16'd15,   16'h0001, 5'b00000, 1});
    tbl.push_back('{OP_ALSH,  16'h0003, 16'd4,    16'h0030, 5'b00000, 1});
    tbl.push_back('{OP_ARSH,  16'h8000, 16'd4,    16'hF800, 5'b00000, 1});
    tbl.push_back('{OP_NOT,   16'h00FF, 16'h1234, 16'hFF00, 5'b00000, 1});
    tbl.push_back('{OP_AND,   16'hF0F0, 16'hFF00, 16'hF000, 5'b00000, 1});
    tbl.push_back('{OP_OR,    16'h0000, 16'h0000, 16'h0000, 5'b01000, 1});
    tbl.push_back('{OP_XOR,   16'hAAAA, 16'hAAAA, 16'h0000, 5'b01000, 1});
    tbl.push_back('{OP_MUL,   16'hFFFD, 16'h0007, 16'hFFEB, 5'b10000, 17});
    tbl.push_back('{OP_MUL,   16'h0000, 16'h1234, 16'h0000, 5'b01000, 17});
`ifdef ALU_MC_DIV_EN
    tbl.push_back('{OP_DIVU,  16'd100,  16'd7,    16'd14,   5'b00000, 17});
    tbl.push_back('{OP_DIVU,  16'd5,    16'd0,    16'hFFFF, 5'b00100, 1});
    tbl.push_back('{OP_DIVU,  16'd3,    16'd7,    16'h0000, 5'b01000, 17});
`else
    tbl.push_back('{OP_DIVU,  16'd100,  16'd7,    16'h0000, 5'b00000, 1});
    tbl.push_back('{OP_DIVU,  16'd0,    16'd0,    16'h0000, 5'b00000, 1});
`endif

    // Reset state
    repeat (2) @(negedge I_CLK);
    check("rst_c", 32'(O_C), 32'h0);
    check("rst_status", 32'(O_STATUS), 32'h0);
    check("rst_busy", 32'(O_BUSY), 32'h0);
    check("rst_done", 32'(O_DONE), 32'h0);
    I_NRESET = 1'b1;

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].op, tbl[i].a, tbl[i].b, ec, es, el);
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, rc, rs, rl);
      check($sformatf("tbl%0d_c", i), 32'(rc), 32'(tbl[i].c));
      check($sformatf("tbl%0d_status", i), 32'(rs), 32'(tbl[i].st));
      check($sformatf("tbl%0d_latency", i), 32'(rl), 32'(tbl[i].lat));
    end

    // MUL: busy length, single done pulse, start while busy ignored
    begin
      int i, done_at, busy_cnt, extra;
      model(OP_MUL, 16'hFFFD, 16'h0007, ec, es, el);
      @(negedge I_CLK);
      I_START = 1'b1; I_OPCODE = OP_MUL; I_A = 16'hFFFD; I_B = 16'h0007;
      @(posedge I_CLK);
      @(negedge I_CLK);
      I_START = 1'b0;
      i = 1; done_at = 0; busy_cnt = 0;
      while (i <= 40 && done_at == 0) begin
        if (O_BUSY) busy_cnt++;
        if (O_DONE) done_at = i;
        if (i == 5) begin
          I_START = 1'b1; I_OPCODE = OP_ADD; I_A = 16'h0001; I_B = 16'h0001;
        end
        if (i == 6) I_START = 1'b0;
        if (done_at == 0) begin
          @(negedge I_CLK);
          i++;
        end
      end
      check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
      check("mul_done_latency", 32'(done_at), 32'd17);
      check("mul_c", 32'(O_C), 32'(ec));
      check("mul_status", 32'(O_STATUS), 32'(es));
      extra = 0;
      repeat (4) begin
        @(negedge I_CLK);
        if (O_DONE) extra++;
      end
      check("mul_done_pulse_and_ignored_start", 32'(extra), 32'd0);
      check("mul_c_held", 32'(O_C), 32'hFFEB);
    end

    // Reset in the middle of a MUL clears outputs and the carry register
    begin
      int dones;
      model(OP_ADDU, 16'hFFFF, 16'h0002, ec, es, el);
      run_op(OP_ADDU, 16'hFFFF, 16'h0002, rc, rs, rl);
      check("pre_rst_c", 32'(rc), 32'(ec));
      check("pre_rst_status", 32'(rs), 32'(es));
      @(negedge I_CLK);
      I_START = 1'b1; I_OPCODE = OP_MUL; I_A = 16'h0003; I_B = 16'h0005;
      @(posedge I_CLK);
      @(negedge I_CLK);
      I_START = 1'b0;
      repeat (7) @(negedge I_CLK);
      I_NRESET = 1'b0;
      #1;
      check("midrst_c", 32'(O_C), 32'h0);
      check("midrst_status", 32'(O_STATUS), 32'h0);
      check("midrst_busy", 32'(O_BUSY), 32'h0);
      check("midrst_done", 32'(O_DONE), 32'h0);
      @(negedge I_CLK);
      I_NRESET = 1'b1;
      m_carry = 1'b0;
      dones = 0;
      repeat (25) begin
        @(negedge I_CLK);
        if (O_DONE || O_BUSY) dones++;
      end
      check("midrst_no_done", 32'(dones), 32'd0);
      check("midrst_c_after", 32'(O_C), 32'h0);
      model(OP_ADDCU, 16'h0001, 16'h0001, ec, es, el);
      run_op(OP_ADDCU, 16'h0001, 16'h0001, rc, rs, rl);
      check("midrst_carry_cleared", 32'(rc), 32'(ec));
    end

    // Back-to-back single-cycle ops at one per cycle
    begin
      logic [3:0]  bop[3];
      logic [15:0] ba[3], bb[3];
      bop[0] = OP_ADD;  ba[0] = 16'h0001; bb[0] = 16'h0002;
      bop[1] = OP_XOR;  ba[1] = 16'hF0F0; bb[1] = 16'h0F0F;
      bop[2] = OP_SUBU; ba[2] = 16'h0001; bb[2] = 16'h0001;
      @(negedge I_CLK);
      for (int k = 0; k < 3; k++) begin
        I_START = 1'b1; I_OPCODE = bop[k]; I_A = ba[k]; I_B = bb[k];
        @(negedge I_CLK);
        model(bop[k], ba[k], bb[k], ec, es, el);
        check($sformatf("b2b%0d_done", k), 32'(O_DONE), 32'h1);
        check($sformatf("b2b%0d_c", k), 32'(O_C), 32'(ec));
        check($sformatf("b2b%0d_status", k), 32'(O_STATUS), 32'(es));
      end
      I_START = 1'b0;
      @(negedge I_CLK);
      check("b2b_done_drops", 32'(O_DONE), 32'h0);
    end

    // Randomized ops against the model
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [15:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (op == OP_LSH || op == OP_RSH || op == OP_ALSH || op == OP_ARSH)
        b = 16'($urandom_range(0, 20));
      if (op == OP_DIVU && $urandom_range(0, 3) == 0) b = 16'h0;
      if (op == OP_DIVU && $urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 300));
      model(op, a, b, ec, es, el);
      run_op(op, a, b, rc, rs, rl);
      check($sformatf("rnd%0d_op%0d_c", n, op), 32'(rc), 32'(ec));
      check($sformatf("rnd%0d_op%0d_status", n, op), 32'(rs), 32'(es));
      check($sformatf("rnd%0d_op%0d_latency", n, op), 32'(rl), 32'(el));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
